// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, reset vector, fetch states and instruction field positions
package cpu_pkg;

    localparam logic [15:0] RESET_VEC   = 16'h0000;
    localparam logic [3:0]  BR_OPCODE   = 4'hC;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OFF_MSB = 7;
    localparam int OFF_LSB = 0;

    typedef enum logic [1:0] {RST, FETCH, ISSUE, HALT} fetch_state_e;

    // Branch offset is an 8-bit two's-complement field widened to a full address
    function automatic logic [15:0] sext_off(input logic [15:0] ins);
        return {{8{ins[OFF_MSB]}}, ins[OFF_MSB:OFF_LSB]};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// pc_next: next-PC selection from the current instruction and the branch-condition result
module pc_next #(
    parameter logic [3:0] BR_OP = 4'hC
) (
    input  logic [15:0] pc_i,
    input  logic [15:0] ir_i,
    input  logic        br_i,
    output logic [15:0] npc_o,
    output logic        taken_o
);
    import cpu_pkg::*;

    // br only matters for branch opcodes; target is relative to pc + 1 and wraps silently
    always_comb begin
        taken_o = (ir_i[OPC_MSB:OPC_LSB] == BR_OP) && br_i;
        npc_o   = pc_i + 16'd1 + (taken_o ? sext_off(ir_i) : 16'h0000);
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction fetch over req/ack, IR hand-off and taken-branch counter
module fetch_unit #(
    parameter logic [15:0] RESET_VEC   = cpu_pkg::RESET_VEC,
    parameter logic [3:0]  BR_OPCODE   = cpu_pkg::BR_OPCODE,
    parameter logic [3:0]  HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        br,
    output logic [15:0] pc,
    output logic        halted,
    output logic [15:0] br_taken_cnt
);
    import cpu_pkg::*;

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d, ir_q, ir_d, cnt_q, cnt_d;
    logic         ir_valid_q, ir_valid_d, halted_q, halted_d;
    logic [15:0]  npc;
    logic         taken;

    pc_next #(.BR_OP(BR_OPCODE)) u_pc_next (
        .pc_i    (pc_q),
        .ir_i    (ir_q),
        .br_i    (br),
        .npc_o   (npc),
        .taken_o (taken)
    );

    // Request is decoded from state so an asynchronous reset drops it without a clock edge
    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = pc_q;
    assign ir           = ir_q;
    assign ir_valid     = ir_valid_q;
    assign pc           = pc_q;
    assign halted       = halted_q;
    assign br_taken_cnt = cnt_q;

    // Next-state: fetch until ack, hold IR until consumed, then advance PC or stop on HALT
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            RST:   state_d = FETCH;
            FETCH: if (imem_ack) begin
                ir_d       = imem_rdata;
                ir_valid_d = 1'b1;
                state_d    = ISSUE;
            end
            ISSUE: if (ir_valid_q && ir_ready) begin
                ir_valid_d = 1'b0;
                if (ir_q[OPC_MSB:OPC_LSB] == HALT_OPCODE) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    pc_d    = npc;
                    state_d = FETCH;
                    cnt_d   = (taken && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
                end
            end
            default: ;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST;
            pc_q       <= RESET_VEC;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with a memory responder, consumer model and negedge monitor
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [15:0] imem_addr, imem_rdata = 16'h0000;
    logic [15:0] ir, pc, br_taken_cnt;
    logic        ir_valid, ir_ready = 1'b0, br = 1'b0, halted;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .br           (br),
        .pc           (pc),
        .halted       (halted),
        .br_taken_cnt (br_taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] pc; logic [15:0] ir;} cons_t;

    cons_t       cq[$];
    logic [15:0] fq[$];
    logic [15:0] mem [logic [15:0]];
    bit          br_tab [logic [15:0]];
    bit          br_default = 1'b0;
    int          ack_delay = 0, ready_delay = 0;
    int          errors = 0, checks = 0;
    int          cyc = 0, fs_prev = 0, fs_last = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // Instruction memory: acks after ack_delay waiting cycles, data valid with ack
    initial begin
        int wc = 0;
        forever begin
            @(posedge clk); #1;
            if (imem_req) begin
                imem_ack   = (wc >= ack_delay);
                imem_rdata = rd(imem_addr);
                wc         = imem_ack ? 0 : wc + 1;
            end else begin
                imem_ack = 1'b0;
                wc       = 0;
            end
        end
    end

    // Consumer and branch-condition source: ready after ready_delay cycles, br from table
    initial begin
        int rc = 0;
        forever begin
            @(posedge clk); #1;
            if (ir_valid) begin
                ir_ready = (rc >= ready_delay);
                br       = br_tab.exists(pc) ? br_tab[pc] : br_default;
                rc       = ir_ready ? 0 : rc + 1;
            end else begin
                ir_ready = 1'b0;
                br       = 1'b0;
                rc       = 0;
            end
        end
    end

    // Monitor: pops expected fetch addresses and consumes, checks hold-stability during stalls
    initial begin
        logic        p_req = 0, p_ack = 0, p_valid = 0, p_ready = 0;
        logic [15:0] p_addr = 0, p_ir = 0, p_pc = 0;
        cons_t       e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (imem_req && !p_req) begin
                    fs_prev = fs_last;
                    fs_last = cyc;
                    if (fq.size() != 0) chk("fetch addr", imem_addr, fq.pop_front());
                    else begin
                        checks++; errors++;
                        $display("FAIL unexpected fetch: got addr %h expected none", imem_addr);
                    end
                end
                if (imem_req && p_req && !p_ack) chk("req stall addr", imem_addr, p_addr);
                if (ir_valid && p_valid && !p_ready) begin
                    chk("stall ir", ir, p_ir);
                    chk("stall pc", pc, p_pc);
                end
                if (ir_valid && ir_ready) begin
                    if (cq.size() != 0) begin
                        e = cq.pop_front();
                        chk("consume pc", pc, e.pc);
                        chk("consume ir", ir, e.ir);
                    end else begin
                        checks++; errors++;
                        $display("FAIL unexpected consume: got ir %h expected none", ir);
                    end
                end
            end
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            p_valid = ir_valid; p_ready = ir_ready; p_ir = ir; p_pc = pc;
        end
    end

    task automatic ef(input logic [15:0] a);
        fq.push_back(a);
    endtask

    task automatic ec(input logic [15:0] p, input logic [15:0] i);
        cons_t e;
        e.pc = p; e.ir = i;
        cq.push_back(e);
    endtask

    task automatic clear();
        mem.delete();
        br_tab.delete();
        fq.delete();
        cq.delete();
    endtask

    // Reset, check reset values, release and check RST lasts one cycle
    task automatic start();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst imem_req", imem_req, 0);
        chk("rst pc", pc, 16'h0000);
        chk("rst ir", ir, 16'h0000);
        chk("rst ir_valid", ir_valid, 0);
        chk("rst halted", halted, 0);
        chk("rst cnt", br_taken_cnt, 16'h0000);
        rst_n = 1'b1;
        #1 chk("rst release req", imem_req, 0);
    endtask

    task automatic run(input string tag, input logic [15:0] exp_cnt);
        int t = 0;
        while ((fq.size() != 0 || cq.size() != 0) && t < 400) begin
            @(negedge clk); #2;
            t++;
        end
        checks++;
        if (t >= 400) begin
            errors++;
            $display("FAIL %s timeout: got %0d pending expected 0", tag, fq.size() + cq.size());
        end
        chk({tag, " cnt"}, br_taken_cnt, exp_cnt);
    endtask

    initial begin
        // Basic fetch with 2-cycle cadence
        clear(); mem[16'h0000] = 16'h1234;
        ef(16'h0000); ef(16'h0001); ec(16'h0000, 16'h1234);
        start();
        @(negedge clk); chk("first req", imem_req, 1);
        run("basic", 16'd0);
        chk("cadence", 16'(fs_last - fs_prev), 16'd2);

        // Taken branch back by 2, then the same branch not taken, then br on non-branch
        clear(); br_default = 1'b0; br_tab[16'h0000] = 1'b1; br_tab[16'h0010] = 1'b1;
        mem[16'h0000] = 16'hC00F; mem[16'h0010] = 16'hC0FE;
        ef(16'h0000); ef(16'h0010); ef(16'h000F);
        ec(16'h0000, 16'hC00F); ec(16'h0010, 16'hC0FE);
        start(); run("br taken", 16'd2);

        clear(); br_default = 1'b1; br_tab[16'h0010] = 1'b0;
        mem[16'h0000] = 16'hC00F; mem[16'h0010] = 16'hC0FE; mem[16'h0011] = 16'h30FE;
        ef(16'h0000); ef(16'h0010); ef(16'h0011); ef(16'h0012);
        ec(16'h0000, 16'hC00F); ec(16'h0010, 16'hC0FE); ec(16'h0011, 16'h30FE);
        start(); run("br not taken", 16'd1);

        // Wrap: 0 -> FF81 -> FFF0 -> 0070
        clear(); br_default = 1'b1;
        mem[16'h0000] = 16'hC080; mem[16'hFF81] = 16'hC06E; mem[16'hFFF0] = 16'hC07F;
        ef(16'h0000); ef(16'hFF81); ef(16'hFFF0); ef(16'h0070);
        ec(16'h0000, 16'hC080); ec(16'hFF81, 16'hC06E); ec(16'hFFF0, 16'hC07F);
        start(); run("wrap br", 16'd3);

        // Wrap: 0 -> FF81 -> FFFF -> 0000 via sequential increment
        clear(); br_default = 1'b0; br_tab[16'h0000] = 1'b1; br_tab[16'hFF81] = 1'b1;
        mem[16'h0000] = 16'hC080; mem[16'hFF81] = 16'hC07D;
        ef(16'h0000); ef(16'hFF81); ef(16'hFFFF); ef(16'h0000);
        ec(16'h0000, 16'hC080); ec(16'hFF81, 16'hC07D); ec(16'hFFFF, 16'h0000);
        start(); run("wrap seq", 16'd2);

        // Memory and consumer stalls
        clear(); br_default = 1'b0; ack_delay = 3; ready_delay = 4;
        mem[16'h0000] = 16'h1111; mem[16'h0001] = 16'h2222;
        ef(16'h0000); ef(16'h0001); ef(16'h0002);
        ec(16'h0000, 16'h1111); ec(16'h0001, 16'h2222);
        start(); run("stall", 16'd0);

        // Asynchronous reset in the middle of a fetch
        clear(); ack_delay = 5; ready_delay = 0; mem[16'h0000] = 16'h5555;
        ef(16'h0000); ef(16'h0000); ef(16'h0001); ec(16'h0000, 16'h5555);
        start();
        repeat (2) @(posedge clk);
        #3 chk("pre-rst req", imem_req, 1);
        rst_n = 1'b0;
        #1 chk("async rst req", imem_req, 0);
        ack_delay = 0;
        start(); run("async rst", 16'd0);

        // HALT stops fetching until reset
        clear(); mem[16'h0000] = 16'h0001; mem[16'h0001] = 16'hF000;
        ef(16'h0000); ef(16'h0001); ec(16'h0000, 16'h0001); ec(16'h0001, 16'hF000);
        start(); run("halt", 16'd0);
        @(negedge clk);
        chk("halted", halted, 1);
        chk("halt ir_valid", ir_valid, 0);
        chk("halt pc", pc, 16'h0001);
        repeat (20) begin
            @(negedge clk);
            chk("halt req", imem_req, 0);
        end

        // Normal fetch resumes after reset
        clear(); mem[16'h0000] = 16'h2000;
        ef(16'h0000); ef(16'h0001); ec(16'h0000, 16'h2000);
        start(); run("resume", 16'd0);
        chk("resume halted", halted, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
